// File: rtl/qq_pkg.sv
// Shared types and constants for the qq_front command front end.
package qq_pkg;

   typedef enum logic {
      QQ_OP_ENQ = 1'b0,
      QQ_OP_DEQ = 1'b1
   } qq_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2
   } qq_state_t;

   localparam int QQ_CNT_W = 16;

endpackage

// File: rtl/qq_cmd_fifo.sv
// Command FIFO: pointers one bit wider than the address, so full and empty
// are told apart by the MSB; head word is read combinationally from LUT RAM.
module qq_cmd_fifo #(
   parameter int DW = 9,
   parameter int FD = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);
   localparam int AW = $clog2(FD);

   logic [AW:0]   wr_ptr_reg;
   logic [AW:0]   rd_ptr_reg;
   logic [DW-1:0] mem [FD];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr_reg[AW-1:0]];
   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/qq_front.sv
// Front end serialising enqueue/dequeue commands onto a priority-queue core.
// Optional statistics counters are enabled by defining QQ_FRONT_STATS_EN.
module qq_front
   import qq_pkg::*;
#(
   parameter int W  = 8,
   parameter int FD = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   input  logic         cmd_op,
   input  logic [W-1:0] cmd_key,
   output logic         cmd_ready,
   output logic         res_valid,
   output logic [W-1:0] res_key,
   input  logic         res_ready,
   output logic         err,
   output logic         q_enq,
   output logic         q_deq,
   output logic [W-1:0] q_din,
   input  logic         q_rdy,
   input  logic         q_full,
   input  logic         q_empty,
   input  logic [W-1:0] q_head
`ifdef QQ_FRONT_STATS_EN
   ,
   output logic [QQ_CNT_W-1:0] n_enq,
   output logic [QQ_CNT_W-1:0] n_deq,
   output logic [QQ_CNT_W-1:0] n_err
`endif
);

   qq_state_t    state_reg;
   logic         alive_reg;
   logic         res_valid_reg;
   logic [W-1:0] res_key_reg;

   logic         fifo_full;
   logic         fifo_empty;
   logic         push;
   logic         pop;
   logic [W:0]   head;
   qq_op_t       head_op;
   logic [W-1:0] head_key;
   logic         res_free;
   logic         issue_enq;
   logic         issue_deq;

   qq_cmd_fifo #(
      .DW(W + 1),
      .FD(FD)
   ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push),
      .pop  (pop),
      .din  ({cmd_op, cmd_key}),
      .dout (head),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   assign head_op  = qq_op_t'(head[W]);
   assign head_key = head[W-1:0];
   assign res_free = !res_valid_reg || res_ready;

   // A dequeue only leaves the FIFO when its result has somewhere to land.
   assign pop = !rst && (state_reg == IDLE) && !fifo_empty && q_rdy &&
                ((head_op == QQ_OP_ENQ) || res_free);

   assign issue_enq = pop && (head_op == QQ_OP_ENQ) && !q_full;
   assign issue_deq = pop && (head_op == QQ_OP_DEQ) && !q_empty;

   assign err       = pop && !issue_enq && !issue_deq;
   assign q_enq     = issue_enq;
   assign q_deq     = issue_deq;
   assign q_din     = issue_enq ? head_key : '0;
   assign cmd_ready = alive_reg && !rst && (!fifo_full || pop);
   assign push      = cmd_valid && cmd_ready;
   assign res_valid = res_valid_reg;
   assign res_key   = res_key_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         alive_reg     <= 1'b0;
         res_valid_reg <= 1'b0;
         res_key_reg   <= '0;
      end else begin
         alive_reg <= 1'b1;
         case (state_reg)
            IDLE:    if (issue_enq || issue_deq) state_reg <= ISSUE;
            ISSUE:   state_reg <= BUSY;
            BUSY:    if (q_rdy) state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
         if (issue_deq) begin
            res_key_reg   <= q_head;
            res_valid_reg <= 1'b1;
         end else if (res_valid_reg && res_ready) begin
            res_valid_reg <= 1'b0;
         end
      end
   end

`ifdef QQ_FRONT_STATS_EN
   logic [2:0] stat_inc;
   assign stat_inc = {err, issue_deq, issue_enq};

   for (genvar gi = 0; gi < 3; gi++) begin : g_stat
      logic [QQ_CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_reg <= '0;
         end else if (stat_inc[gi] && (cnt_reg != {QQ_CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
      end
   end

   assign n_enq = g_stat[0].cnt_reg;
   assign n_deq = g_stat[1].cnt_reg;
   assign n_err = g_stat[2].cnt_reg;
`endif

endmodule

// File: doc/qq_front.md
QQ_FRONT -- requirements
Module: qq_front

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning key width in bits.
REQ-002 The block SHALL have parameter FD, default 4, power of two ≥2, meaning command FIFO depth.
REQ-003 The block SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port cmd_valid  input  1  upstream command present.
REQ-006 The block SHALL have port cmd_op  input  1  0 = enqueue, 1 = dequeue.
REQ-007 The block SHALL have port cmd_key  input  W  key for enqueue, ignored for dequeue.
REQ-008 The block SHALL have port cmd_ready  output  1  command FIFO not full.
REQ-009 The block SHALL have port res_valid  output  1  dequeued key available.
REQ-010 The block SHALL have port res_key  output  W  dequeued key.
REQ-011 The block SHALL have port res_ready  input  1  downstream accepts result.
REQ-012 The block SHALL have port err  output  1  one-cycle pulse on a rejected command.
REQ-013 The block SHALL have port q_enq  output  1  one-cycle enqueue strobe to queue core enq_i.
REQ-014 The block SHALL have port q_deq  output  1  one-cycle dequeue strobe to queue core deq_i.
REQ-015 The block SHALL have port q_din  output  W  key presented with q_enq.
REQ-016 The block SHALL have ports q_rdy, q_full, q_empty  input  1 each  core rdy/full/empty.
REQ-017 The block SHALL have port q_head  input  W  core head (minimum) key, valid when q_rdy=1 and q_empty=0.

Function
REQ-018 A command SHALL be written to the FIFO in any cycle with cmd_valid=1 and cmd_ready=1.
REQ-019 The FSM SHALL have states IDLE, ISSUE, BUSY.
REQ-020 IDLE SHALL pop the FIFO head when the FIFO is non-empty, q_rdy=1, and, for a dequeue, the result register is free (res_valid=0 or res_ready=1).
REQ-021 A popped enqueue with q_full=0 SHALL drive q_enq=1 and q_din=key in that cycle and move to ISSUE.
REQ-022 A popped dequeue with q_empty=0 SHALL drive q_deq=1, load q_head into res_key, set res_valid next cycle, and move to ISSUE.
REQ-023 A popped enqueue with q_full=1, or dequeue with q_empty=1, SHALL be dropped with err=1 for one cycle, no strobe, and the FSM SHALL stay in IDLE.
REQ-024 ISSUE SHALL last exactly one cycle, ignoring q_rdy, then move to BUSY.
REQ-025 BUSY SHALL move to IDLE in the cycle q_rdy=1 is sampled.
REQ-026 At most one core operation SHALL be outstanding, and q_enq and q_deq SHALL never be high together.
REQ-027 Minimum command-to-strobe latency SHALL be 1 cycle (write cycle N, strobe cycle N+1).
REQ-028 res_valid SHALL clear on res_valid&&res_ready unless a new result loads the same cycle.
REQ-029 A FIFO push and pop in the same cycle SHALL both occur when the FIFO is full, with cmd_ready=0 preventing the push only if no pop occurs.
REQ-030 FIFO pointers SHALL be $clog2(FD)+1 bits and wrap modulo 2·FD, with full/empty from MSB comparison.

Reset
REQ-031 During rst=1 the FSM SHALL be IDLE, the FIFO empty, and res_valid, err, q_enq, q_deq, res_key, q_din all 0.
REQ-032 During rst=1, cmd_ready SHALL be 0; it SHALL rise the cycle after reset release.
REQ-033 Reset mid-operation SHALL discard FIFO contents and any pending result without any further strobe.

Configuration
REQ-034 With QQ_FRONT_STATS_EN defined, the block SHALL add 16-bit outputs n_enq, n_deq, n_err, counting issued enqueues, issued dequeues and err pulses, saturating at 16'hFFFF, and cleared by rst.
REQ-035 Without QQ_FRONT_STATS_EN, the block SHALL have neither these ports nor their counters.

Structure
REQ-036 Package qq_pkg SHALL hold the op typedef (QQ_OP_ENQ=0, QQ_OP_DEQ=1), the FSM state typedef, and the counter width constant.
REQ-037 The command FIFO SHALL be sub-module qq_cmd_fifo (width W+1, depth FD).

Verification
REQ-038 The bench SHALL cover: enq 8'h30, enq 8'h10, deq with the core model sorting -> q_enq pulses with q_din 30 then 10, res_key=8'h10, err never set.
REQ-039 The bench SHALL cover: deq while q_empty=1 -> err pulse for 1 cycle, no q_deq, res_valid stays 0.
REQ-040 The bench SHALL cover: core depth 4 filled, 5th enq 8'h55 -> err=1, q_enq not asserted.
REQ-041 The bench SHALL cover: res_ready=0 with 2 deqs queued -> first result held, second q_deq withheld until res_ready=1.
REQ-042 The bench SHALL cover: 6 back-to-back commands with FD=4 and core rdy held low 10 cycles -> cmd_ready=0 after 4 writes (5 if one pops), nothing lost, order preserved.
REQ-043 The bench SHALL cover: rst in BUSY with 2 FIFO entries -> outputs at reset values next cycle, no strobe after release.
